// File: rtl/ascensor_despachador_if.sv
// Bundle of the scheduler's signals: floor calls, car position and limit feedback, and the car commands.
// The dispatcher connects through the slave modport, and the car/panel side connects through the master modport.
interface ascensor_despachador_if #(
  parameter int N_PISOS = 4,
  parameter int PISO_W  = 2
);
  logic [N_PISOS-1:0] call_btn;
  logic [PISO_W-1:0]  piso_actual;
  logic               piso_valid;
  logic               top_lim;
  logic               bott_lim;
  logic               go_up;
  logic               go_down;
  logic               halt;
  logic [N_PISOS-1:0] pending;
  logic               door_open;

  modport master (
    output call_btn, piso_actual, piso_valid, top_lim, bott_lim,
    input  go_up, go_down, halt, pending, door_open
  );

  modport slave (
    input  call_btn, piso_actual, piso_valid, top_lim, bott_lim,
    output go_up, go_down, halt, pending, door_open
  );
endinterface

// File: rtl/ascensor_despachador.sv
// Collective (SCAN) floor-call dispatcher that produces go_up / go_down / halt commands for the elevator car.
// Defining ASC_EMERG_STOP_EN adds an emerg input and an EMERG state that halts the car and drops every pending call.
module ascensor_despachador #(
  parameter int N_PISOS = 4,
  parameter int PISO_W  = 2,
  parameter int DWELL   = 3
) (
  input logic CLK,
  input logic RESET_L,
`ifdef ASC_EMERG_STOP_EN
  input logic emerg,
`endif
  ascensor_despachador_if.slave bus
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

`ifdef ASC_EMERG_STOP_EN
  typedef enum logic [2:0] {ST_IDLE, ST_SUBE, ST_BAJA, ST_DWELL, ST_EMERG} estado_t;
`else
  typedef enum logic [2:0] {ST_IDLE, ST_SUBE, ST_BAJA, ST_DWELL} estado_t;
`endif

  estado_t            estado, estado_n;
  logic               dir_up, dir_up_n;
  logic [N_PISOS-1:0] pending_q, pending_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [PISO_W-1:0]  piso_dwell, piso_dwell_n;
  logic [PISO_W-1:0]  piso_abrir, ref_piso;
  logic               abrir, ahead_up, ahead_dn, pend_here;
  logic               go_up_q, go_down_q, halt_q, door_q;

  // While the doors are open, look ahead from the floor being served rather than from the sensor.
  always_comb begin
    ref_piso = (estado == ST_DWELL) ? piso_dwell : bus.piso_actual;
    ahead_up = 1'b0;
    ahead_dn = 1'b0;
    for (int i = 0; i < N_PISOS; i++) begin
      if (pending_q[i] && (i > int'(ref_piso))) ahead_up = 1'b1;
      if (pending_q[i] && (i < int'(ref_piso))) ahead_dn = 1'b1;
    end
    pend_here = bus.piso_valid && pending_q[bus.piso_actual];
  end

  always_comb begin
    estado_n     = estado;
    dir_up_n     = dir_up;
    cnt_n        = cnt;
    piso_dwell_n = piso_dwell;
    abrir        = 1'b0;
    piso_abrir   = bus.piso_actual;
    case (estado)
      ST_IDLE: begin
        if (pend_here) abrir = 1'b1;
        else if (bus.piso_valid && ahead_up && !bus.top_lim && (dir_up || !ahead_dn)) begin
          estado_n = ST_SUBE;
          dir_up_n = 1'b1;
        end else if (bus.piso_valid && ahead_dn && !bus.bott_lim) begin
          estado_n = ST_BAJA;
          dir_up_n = 1'b0;
        end
      end
      ST_SUBE: begin
        if (pend_here) abrir = 1'b1;
        else if (bus.top_lim) begin
          if (pending_q[N_PISOS-1]) begin
            abrir      = 1'b1;
            piso_abrir = PISO_W'(N_PISOS - 1);
          end else estado_n = ST_IDLE;
        end
      end
      ST_BAJA: begin
        if (pend_here) abrir = 1'b1;
        else if (bus.bott_lim) begin
          if (pending_q[0]) begin
            abrir      = 1'b1;
            piso_abrir = '0;
          end else estado_n = ST_IDLE;
        end
      end
      ST_DWELL: begin
        // Prefer the current sweep direction and reverse only when nothing is left ahead.
        if (cnt == CNT_W'(DWELL - 1)) begin
          if (dir_up && ahead_up && !bus.top_lim) estado_n = ST_SUBE;
          else if (!dir_up && ahead_dn && !bus.bott_lim) estado_n = ST_BAJA;
          else if (dir_up && ahead_dn && !bus.bott_lim) begin
            estado_n = ST_BAJA;
            dir_up_n = 1'b0;
          end else if (!dir_up && ahead_up && !bus.top_lim) begin
            estado_n = ST_SUBE;
            dir_up_n = 1'b1;
          end else estado_n = ST_IDLE;
        end else cnt_n = cnt + 1'b1;
      end
      default: estado_n = ST_IDLE;
    endcase
    if (abrir) begin
      estado_n     = ST_DWELL;
      cnt_n        = '0;
      piso_dwell_n = piso_abrir;
    end

    // A served floor's clear beats a simultaneous new call, but only for that floor.
    pending_n = pending_q | bus.call_btn;
    if (estado == ST_DWELL) pending_n[piso_dwell] = 1'b0;
    if (abrir) pending_n[piso_abrir] = 1'b0;
`ifdef ASC_EMERG_STOP_EN
    if (emerg) begin
      estado_n  = ST_EMERG;
      pending_n = '0;
    end
`endif
  end

  // Commands are decoded from the next state so that every output is a flop.
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      estado     <= ST_IDLE;
      dir_up     <= 1'b1;
      pending_q  <= '0;
      cnt        <= '0;
      piso_dwell <= '0;
      go_up_q    <= 1'b0;
      go_down_q  <= 1'b0;
      halt_q     <= 1'b1;
      door_q     <= 1'b0;
    end else begin
      estado     <= estado_n;
      dir_up     <= dir_up_n;
      pending_q  <= pending_n;
      cnt        <= cnt_n;
      piso_dwell <= piso_dwell_n;
      go_up_q    <= (estado_n == ST_SUBE);
      go_down_q  <= (estado_n == ST_BAJA);
      halt_q     <= (estado_n != ST_SUBE) && (estado_n != ST_BAJA);
      door_q     <= (estado_n == ST_DWELL);
    end
  end

  assign bus.go_up     = go_up_q;
  assign bus.go_down   = go_down_q;
  assign bus.halt      = halt_q;
  assign bus.pending   = pending_q;
  assign bus.door_open = door_q;

endmodule

// File: tb/tb_ascensor_despachador.sv
// Directed bench for ascensor_despachador: a floor-call model is compared against the DUT on every falling edge.
// Literal checkpoints pin the model, and the emergency scenario is built only when ASC_EMERG_STOP_EN is defined.
module tb_ascensor_despachador;
  localparam int N_PISOS = 4;
  localparam int PISO_W  = 2;
  localparam int DWELL   = 3;
  localparam int M_PARADO = 0, M_SUBE = 1, M_BAJA = 2, M_PUERTA = 3, M_EMERG = 4;

  logic CLK = 1'b0;
  logic RESET_L = 1'b1;
`ifdef ASC_EMERG_STOP_EN
  logic emerg = 1'b0;
`endif
  int checks = 0;
  int errors = 0;

  ascensor_despachador_if #(.N_PISOS(N_PISOS), .PISO_W(PISO_W)) bus ();

  ascensor_despachador #(.N_PISOS(N_PISOS), .PISO_W(PISO_W), .DWELL(DWELL)) dut (
    .CLK(CLK),
    .RESET_L(RESET_L),
`ifdef ASC_EMERG_STOP_EN
    .emerg(emerg),
`endif
    .bus(bus.slave)
  );

  always #5 CLK = ~CLK;

  // Model of the car: mode, preferred direction, outstanding calls, and remaining door time.
  int               m_mode = M_PARADO;
  bit               m_dir_up = 1'b1;
  bit [N_PISOS-1:0] m_pend = '0;
  int               m_left = 0;
  int               m_floor = 0;
  bit               tl_prev = 1'b0;
  bit               bl_prev = 1'b0;

  function automatic int count_above(bit [N_PISOS-1:0] p, int f);
    int n = 0;
    for (int i = f + 1; i < N_PISOS; i++) n += int'(p[i]);
    return n;
  endfunction

  function automatic int count_below(bit [N_PISOS-1:0] p, int f);
    int n = 0;
    for (int i = 0; i < f; i++) n += int'(p[i]);
    return n;
  endfunction

  function automatic void model_step();
    bit [N_PISOS-1:0] np;
    int f, door_at, up, dn;
    bit v, tl, bl;
    f = int'(bus.piso_actual);
    v = bus.piso_valid;
    tl = bus.top_lim;
    bl = bus.bott_lim;
    np = m_pend | bus.call_btn;
    door_at = -1;
`ifdef ASC_EMERG_STOP_EN
    if (emerg) begin
      m_mode = M_EMERG;
      m_pend = '0;
      return;
    end
`endif
    case (m_mode)
      M_PARADO: begin
        up = count_above(m_pend, f);
        dn = count_below(m_pend, f);
        if (v && m_pend[f]) door_at = f;
        else if (v && up > 0 && !tl && (m_dir_up || dn == 0)) begin m_mode = M_SUBE; m_dir_up = 1; end
        else if (v && dn > 0 && !bl) begin m_mode = M_BAJA; m_dir_up = 0; end
      end
      M_SUBE: begin
        if (v && m_pend[f]) door_at = f;
        else if (tl) begin
          if (m_pend[N_PISOS-1]) door_at = N_PISOS - 1;
          else m_mode = M_PARADO;
        end
      end
      M_BAJA: begin
        if (v && m_pend[f]) door_at = f;
        else if (bl) begin
          if (m_pend[0]) door_at = 0;
          else m_mode = M_PARADO;
        end
      end
      M_PUERTA: begin
        np[m_floor] = 1'b0;
        m_left--;
        if (m_left == 0) begin
          up = count_above(m_pend, m_floor);
          dn = count_below(m_pend, m_floor);
          if (m_dir_up && up > 0 && !tl) m_mode = M_SUBE;
          else if (!m_dir_up && dn > 0 && !bl) m_mode = M_BAJA;
          else if (dn > 0 && !bl) begin m_mode = M_BAJA; m_dir_up = 0; end
          else if (up > 0 && !tl) begin m_mode = M_SUBE; m_dir_up = 1; end
          else m_mode = M_PARADO;
        end
      end
      default: m_mode = M_PARADO;
    endcase
    if (door_at >= 0) begin
      m_mode = M_PUERTA;
      m_left = DWELL;
      m_floor = door_at;
      np[door_at] = 1'b0;
    end
    m_pend = np;
  endfunction

  always @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      m_mode = M_PARADO;
      m_dir_up = 1'b1;
      m_pend = '0;
      m_left = 0;
      m_floor = 0;
    end else model_step();
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    checkOutput("go_up", 32'(bus.go_up), 32'(m_mode == M_SUBE));
    checkOutput("go_down", 32'(bus.go_down), 32'(m_mode == M_BAJA));
    checkOutput("halt", 32'(bus.halt), 32'(m_mode != M_SUBE && m_mode != M_BAJA));
    checkOutput("door_open", 32'(bus.door_open), 32'(m_mode == M_PUERTA));
    checkOutput("pending", 32'(bus.pending), 32'(m_pend));
    checkOutput("one_hot_cmd", 32'($countones({bus.go_up, bus.go_down, bus.halt})), 32'd1);
    if (tl_prev) checkOutput("up_at_top_lim", 32'(bus.go_up), 32'd0);
    if (bl_prev) checkOutput("down_at_bott_lim", 32'(bus.go_down), 32'd0);
    tl_prev = bus.top_lim;
    bl_prev = bus.bott_lim;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #2;
    end
  endtask

  task automatic applyStimulus(input logic [N_PISOS-1:0] call, input int piso, input bit valid,
                               input bit tl, input bit bl);
    bus.call_btn    = call;
    bus.piso_actual = PISO_W'(piso);
    bus.piso_valid  = valid;
    bus.top_lim     = tl;
    bus.bott_lim    = bl;
  endtask

  initial begin
    applyStimulus(4'b0000, 0, 0, 0, 0);
    #1 RESET_L = 1'b0;
    tick(2);
    RESET_L = 1'b1;
    checkOutput("lit_reset_halt", 32'(bus.halt), 32'd1);
    checkOutput("lit_reset_pending", 32'(bus.pending), 32'd0);
    tick(20);
    checkOutput("lit_idle_halt", 32'(bus.halt), 32'd1);

    $display("[TB] single up call");
    applyStimulus(4'b0100, 0, 1, 0, 1); tick(1);
    checkOutput("lit_up_pending", 32'(bus.pending), 32'h4);
    checkOutput("lit_up_still_halt", 32'(bus.halt), 32'd1);
    applyStimulus(4'b0000, 0, 1, 0, 1); tick(1);
    checkOutput("lit_up_go_up", 32'(bus.go_up), 32'd1);
    applyStimulus(4'b0000, 1, 1, 0, 0); tick(1);
    applyStimulus(4'b0000, 1, 0, 0, 0); tick(1);
    applyStimulus(4'b0000, 2, 1, 0, 0); tick(1);
    checkOutput("lit_up_door", 32'(bus.door_open), 32'd1);
    checkOutput("lit_up_cleared", 32'(bus.pending), 32'd0);
    tick(2);
    checkOutput("lit_up_door_last", 32'(bus.door_open), 32'd1);
    tick(1);
    checkOutput("lit_up_door_closed", 32'(bus.door_open), 32'd0);

    $display("[TB] scan ordering");
    applyStimulus(4'b1000, 1, 1, 0, 0); tick(1);
    applyStimulus(4'b0001, 1, 1, 0, 0); tick(1);
    checkOutput("lit_scan_go_up", 32'(bus.go_up), 32'd1);
    applyStimulus(4'b0000, 1, 0, 0, 0); tick(1);
    checkOutput("lit_scan_pending", 32'(bus.pending), 32'h9);
    applyStimulus(4'b0000, 2, 1, 0, 0); tick(1);
    checkOutput("lit_scan_keeps_up", 32'(bus.go_up), 32'd1);
    applyStimulus(4'b0000, 3, 1, 1, 0); tick(1);
    checkOutput("lit_scan_top_served", 32'(bus.pending), 32'h1);
    tick(3);
    checkOutput("lit_scan_reverse", 32'(bus.go_down), 32'd1);
    applyStimulus(4'b0000, 2, 1, 0, 0); tick(1);
    applyStimulus(4'b0000, 1, 1, 0, 0); tick(1);
    applyStimulus(4'b0000, 0, 1, 0, 1); tick(1);
    checkOutput("lit_scan_bottom_door", 32'(bus.door_open), 32'd1);
    tick(3);
    checkOutput("lit_scan_idle", 32'(bus.halt), 32'd1);

    $display("[TB] call at current floor");
    applyStimulus(4'b0010, 1, 1, 0, 0); tick(1);
    applyStimulus(4'b0000, 1, 1, 0, 0); tick(1);
    checkOutput("lit_here_door", 32'(bus.door_open), 32'd1);
    applyStimulus(4'b0010, 1, 1, 0, 0); tick(2);
    checkOutput("lit_here_absorbed", 32'(bus.pending), 32'd0);
    applyStimulus(4'b0000, 1, 1, 0, 0); tick(1);
    checkOutput("lit_here_closed", 32'(bus.door_open), 32'd0);
    tick(1);

    $display("[TB] limit protection");
    applyStimulus(4'b0100, 1, 1, 0, 0); tick(1);
    applyStimulus(4'b0000, 1, 1, 0, 0); tick(1);
    checkOutput("lit_lim_go_up", 32'(bus.go_up), 32'd1);
    applyStimulus(4'b0000, 1, 0, 1, 0); tick(1);
    checkOutput("lit_lim_top_halt", 32'(bus.halt), 32'd1);
    tick(3);
    checkOutput("lit_lim_no_pos_hold", 32'(bus.pending), 32'h4);
    applyStimulus(4'b0000, 3, 1, 1, 0); tick(1);
    applyStimulus(4'b0000, 2, 1, 0, 0); tick(4);
    applyStimulus(4'b0010, 2, 1, 0, 0); tick(1);
    applyStimulus(4'b0000, 2, 1, 0, 0); tick(1);
    checkOutput("lit_lim_go_down", 32'(bus.go_down), 32'd1);
    applyStimulus(4'b0000, 2, 0, 0, 1); tick(1);
    checkOutput("lit_lim_bott_halt", 32'(bus.halt), 32'd1);
    tick(2);
    applyStimulus(4'b0000, 1, 1, 0, 0); tick(4);

`ifdef ASC_EMERG_STOP_EN
    $display("[TB] emergency stop");
    applyStimulus(4'b0110, 3, 1, 1, 0); tick(1);
    applyStimulus(4'b0000, 3, 1, 1, 0); tick(1);
    checkOutput("lit_em_go_down", 32'(bus.go_down), 32'd1);
    applyStimulus(4'b0001, 3, 0, 0, 0);
    emerg = 1'b1; tick(1);
    checkOutput("lit_em_pending", 32'(bus.pending), 32'd0);
    tick(1);
    checkOutput("lit_em_ignored", 32'(bus.pending), 32'd0);
    applyStimulus(4'b0000, 3, 1, 1, 0);
    emerg = 1'b0; tick(1);
    applyStimulus(4'b0100, 3, 1, 1, 0); tick(1);
    applyStimulus(4'b0000, 3, 1, 1, 0); tick(1);
    checkOutput("lit_em_resume", 32'(bus.go_down), 32'd1);
`endif

    $display("[TB] reset mid-motion");
    applyStimulus(4'b1000, 0, 1, 0, 1); tick(1);
    applyStimulus(4'b0000, 0, 1, 0, 1); tick(1);
    checkOutput("lit_rst_moving", 32'(bus.go_up), 32'd1);
    #1 RESET_L = 1'b0;
    #1;
    checkOutput("lit_rst_halt", 32'(bus.halt), 32'd1);
    checkOutput("lit_rst_pending", 32'(bus.pending), 32'd0);
    tick(2);
    RESET_L = 1'b1;
    tick(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ascensor_despachador.md
Name: ascensor_despachador

Overview:
- Request scheduler sitting directly upstream of the elevator FSM. It latches floor-call buttons and produces the go_up / go_down / halt command triple that drives the elevator car.
- It uses the car's top_lim / bott_lim outputs and a floor-position sensor as feedback.
- Collective (SCAN) policy: keep the current direction while requests remain ahead of the car, then reverse.

Parameters:
- N_PISOS, 4, number of floors; floor 0 is bottom, N_PISOS-1 is top.
- PISO_W, 2, width of floor index; must be at least clog2(N_PISOS).
- DWELL, 3, cycles halt is held at a served floor (door-open time); must be at least 1.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET_L  in  1  asynchronous active-low reset.
- call_btn  in  N_PISOS  call buttons; a level or a pulse of at least 1 cycle registers a request.
- piso_actual  in  PISO_W  current floor index from the position sensor; valid only when piso_valid=1.
- piso_valid  in  1  car is aligned at floor piso_actual.
- top_lim  in  1  car at upper limit (from elevator FSM).
- bott_lim  in  1  car at lower limit (from elevator FSM).
- go_up  out  1  command: move up.
- go_down  out  1  command: move down.
- halt  out  1  command: stop.
- pending  out  N_PISOS  registered outstanding requests.
- door_open  out  1  high during DWELL.

Behaviour:
- All outputs are registered. Reset (asynchronous on RESET_L=0) gives: state=IDLE, go_up=0, go_down=0, halt=1, pending=0, door_open=0, dir_pref=UP, dwell counter=0.
- Exactly one of go_up/go_down/halt is high every cycle after reset. An implementation that produces any other combination is faulty.
- Request latch: pending[i] is set on the edge after call_btn[i]=1. pending[i] is cleared on entry to DWELL at floor i. If both happen in the same cycle, clear wins, but only for the served floor.
- Define ahead_up = any pending above piso_actual, and ahead_dn = any pending below piso_actual.
- States: IDLE, SUBE, BAJA, DWELL.
- IDLE (halt=1):
  - If piso_valid and pending[piso_actual] -> DWELL.
  - Else if ahead_up and (dir_pref=UP or !ahead_dn) -> SUBE, dir_pref=UP.
  - Else if ahead_dn -> BAJA, dir_pref=DN.
  - Else stay in IDLE.
- SUBE (go_up=1): on piso_valid with pending[piso_actual] -> DWELL. top_lim=1 -> DWELL if that floor is pending, else IDLE; go_up is never held while top_lim=1.
- BAJA (go_down=1): mirror of SUBE, using bott_lim.
- DWELL (halt=1, door_open=1):
  - Counts DWELL cycles. New calls for the current floor that arrive during DWELL are absorbed (cleared) without restarting the count.
  - At the end: if ahead in dir_pref -> continue in that direction; else if ahead opposite -> reverse, flip dir_pref; else -> IDLE.
- Latency:
  - call_btn edge -> pending set: 1 cycle.
  - pending set -> command change from IDLE: 1 further cycle.
  - Floor arrival (piso_valid & pending) -> halt=1 on the next edge.
- piso_valid=0 while in IDLE with requests pending: hold halt and do not move. This covers the case where the car has not yet been positioned after power-up.
- A call for the floor currently being passed while moving is served only if piso_valid is high on that edge.
- Reset mid-motion: outputs go immediately to halt=1 and all pending requests are lost.

Optional Feature:
- Macro: ASC_EMERG_STOP_EN.
- When defined:
  - Adds input port emerg (1 bit).
  - emerg=1 forces state EMERG on the next edge from any state: halt=1, go_up=0, go_down=0, door_open=0, pending cleared. call_btn is ignored while emerg=1.
  - When emerg falls, the block returns to IDLE.
- When undefined: no emerg port, no EMERG state, and behaviour is exactly as above.

Test Plan:
- Reset then idle: RESET_L=0 for 2 cycles, release, no calls -> halt=1, go_up=0, go_down=0, pending=0000 for 20 cycles.
- Single up call: car at floor 0 (piso_valid=1), pulse call_btn=0100 -> pending=0100 after 1 cycle, go_up=1 after 2 cycles. Present piso_actual=2 with piso_valid=1 -> halt=1 and door_open=1 for exactly 3 cycles, pending=0000, then IDLE.
- SCAN ordering: car moving up from floor 1 with pending=1001 (floors 0 and 3) -> continues up, serves floor 3 first, reverses with go_down=1, serves floor 0, ends in IDLE.
- Call at current floor while idle: piso_actual=1, call_btn=0010 -> DWELL entered with no go_up/go_down pulse; repeated calls for floor 1 during DWELL are absorbed and the dwell stays 3 cycles.
- Limit protection: in SUBE with no floor-3 request pending, assert top_lim=1 -> halt=1 on the next edge, go_up never high while top_lim=1. Mirror the test with bott_lim in BAJA.
- With ASC_EMERG_STOP_EN: while go_down=1 with pending=0110, raise emerg -> next edge halt=1, pending=0000, calls ignored. Drop emerg -> IDLE, and a fresh call resumes normal operation.
